instr_queue: RTL

- Parametrised successor to the single-stage instruction latch: a DEPTH-entry instruction prefetch queue between memory fetch and the decode/execute stage.
- Each accepted word is split into an opcode field and a signed operand field, and carries its fetch PC as a tag.
- Valid/ready handshakes are used on both sides. A synchronous flush clears the queue for branches.

---
 rtl/cpu_isa_pkg.sv | 24 ++
 rtl/instr_queue_if.sv | 33 +++
 rtl/iq_storage.sv | 48 ++++
 rtl/instr_queue.sv | 72 +++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: default field widths and the opcode set that decode
// interprets from the queue's opcode field.
package cpu_isa_pkg;

    localparam int DEF_OPCODE_W  = 4;
    localparam int DEF_OPERAND_W = 16;
    localparam int DEF_PC_W      = 8;
    localparam int INSTR_W       = DEF_OPCODE_W + DEF_OPERAND_W;

    typedef enum logic [DEF_OPCODE_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_BEQ   = 4'h9,
        OP_HALT  = 4'hF
    } opcode_e;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-to-decode queue bus. Both sides use valid/ready: a transfer happens on a
// rising edge where valid && ready; valid never waits on ready.
interface instr_queue_if #(
    parameter int OPCODE_W  = cpu_isa_pkg::DEF_OPCODE_W,
    parameter int OPERAND_W = cpu_isa_pkg::DEF_OPERAND_W,
    parameter int PC_W      = cpu_isa_pkg::DEF_PC_W,
    parameter int DEPTH     = 4
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                          flush;
    logic                          in_valid;
    logic                          in_ready;
    logic [OPCODE_W+OPERAND_W-1:0] in_data;
    logic [PC_W-1:0]               in_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [OPCODE_W-1:0]           opcode;
    logic signed [OPERAND_W-1:0]   operand;
    logic [PC_W-1:0]               out_pc;
    logic [CNT_W-1:0]              count;

    modport master (
        output flush, in_valid, in_data, in_pc, out_ready,
        input  in_ready, out_valid, opcode, operand, out_pc, count
    );

    modport slave (
        input  flush, in_valid, in_data, in_pc, out_ready,
        output in_ready, out_valid, opcode, operand, out_pc, count
    );

endinterface

// File: rtl/iq_storage.sv
// Circular entry store for the instruction queue: write at the write pointer on
// push, combinational read at the read pointer. Pointers wrap at DEPTH-1.
module iq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= wrap_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= wrap_inc(r_rd_ptr);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry show-ahead instruction prefetch queue with PC tags and a
// synchronous branch flush; splits each word into opcode and signed operand.
module instr_queue import cpu_isa_pkg::*; #(
    parameter int OPCODE_W  = DEF_OPCODE_W,
    parameter int OPERAND_W = DEF_OPERAND_W,
    parameter int PC_W      = DEF_PC_W,
    parameter int DEPTH     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_queue_if.slave  bus
);
    localparam int IW    = OPCODE_W + OPERAND_W;
    localparam int EW    = IW + PC_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic [EW-1:0]    r_last;
    logic [EW-1:0]    w_rdata;
    logic [EW-1:0]    w_head;
    logic             w_push;
    logic             w_pop;

    // in_ready depends on count alone, so a full queue never accepts even while popping.
    assign bus.in_ready  = (r_count != FULL);
    assign bus.out_valid = (r_count != '0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    iq_storage #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_storage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({bus.in_data, bus.in_pc}),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_last  <= '0;
        end else if (bus.flush) begin
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
            if (w_pop) r_last <= w_rdata;
        end
    end

    // When empty the fields hold the last popped entry (zero after reset/flush).
    assign w_head      = bus.out_valid ? w_rdata : r_last;
    assign bus.opcode  = w_head[EW-1 -: OPCODE_W];
    assign bus.operand = w_head[PC_W +: OPERAND_W];
    assign bus.out_pc  = w_head[PC_W-1:0];
    assign bus.count   = r_count;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (r_count <= FULL);
            assert (!(w_pop && r_count == '0));
        end
    end

endmodule
